// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared datapath widths, ALU op codes and operand-A source
//             encodings used by the EX operand stage.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

   localparam int c_XLEN = 32;
   localparam int c_RAW  = 5;

   typedef enum logic [4:0] {
      ALU_SLL = 5'b00000,
      ALU_SLT = 5'b00001,
      ALU_ADD = 5'b00010,
      ALU_AND = 5'b00011,
      ALU_OR  = 5'b00111,
      ALU_SUB = 5'b01010,
      ALU_SRL = 5'b10000
   } alu_ctrl_t;

   // Encoding 2'b11 is reserved; the stage treats it like SRCA_ZERO.
   typedef enum logic [1:0] {
      SRCA_REG  = 2'b00,
      SRCA_PC   = 2'b01,
      SRCA_ZERO = 2'b10
   } srca_sel_t;

   // True when operand A comes from the register file (and so may be bypassed).
   function automatic logic srca_is_reg(input logic [1:0] sel);
      return sel == SRCA_REG;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_mux
//  Purpose  : Bypass select for one operand. Compares a source register
//             index against the EX/MEM and MEM/WB destinations and returns
//             the youngest matching result, else the base value. Register x0
//             is never bypassed.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_mux
   import riscv_pkg::*;
#(
   parameter int XLEN = c_XLEN,
   parameter int RAW  = c_RAW
) (
   input  logic [RAW-1:0]  i_rs,
   input  logic [XLEN-1:0] i_base,
   input  logic            i_exmem_we,
   input  logic [RAW-1:0]  i_exmem_rd,
   input  logic [XLEN-1:0] i_exmem_result,
   input  logic            i_memwb_we,
   input  logic [RAW-1:0]  i_memwb_rd,
   input  logic [XLEN-1:0] i_memwb_result,
   output logic [XLEN-1:0] o_value
);

   logic w_rs_nonzero;
   logic w_exmem_hit;
   logic w_memwb_hit;

   assign w_rs_nonzero = (i_rs != '0);
   assign w_exmem_hit  = w_rs_nonzero & i_exmem_we & (i_exmem_rd == i_rs);
   assign w_memwb_hit  = w_rs_nonzero & i_memwb_we & (i_memwb_rd == i_rs);

   // Youngest producer wins: EX/MEM over MEM/WB over the base value.
   always_comb begin
      o_value = i_base;
      if (w_exmem_hit) begin
         o_value = i_exmem_result;
      end else if (w_memwb_hit) begin
         o_value = i_memwb_result;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_operand_stage
//  Purpose  : ID/EX register stage ahead of the ALU. Resolves SrcA/SrcB from
//             register/PC/zero/immediate sources, holds them with ALUControl
//             and the destination under a valid/ready handshake, with flush.
//  Config   : EX_OPERAND_FWD_EN defined   -> EX/MEM and MEM/WB bypass at
//                                            capture and refresh while held.
//             EX_OPERAND_FWD_EN undefined -> no bypass; RAW dependencies on
//                                            in-flight writers stall InReady.
//  Revision : 1.0  initial release
// ============================================================================
module ex_operand_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = c_XLEN,
   parameter int RAW  = c_RAW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            InValid,
   output logic            InReady,
   input  logic [XLEN-1:0] RD1,
   input  logic [XLEN-1:0] RD2,
   input  logic [XLEN-1:0] ImmExt,
   input  logic [XLEN-1:0] PC,
   input  logic [RAW-1:0]  Rs1,
   input  logic [RAW-1:0]  Rs2,
   input  logic [RAW-1:0]  Rd,
   input  logic [1:0]      ALUSrcA,
   input  logic            ALUSrcB,
   input  logic [4:0]      ALUControlIn,
   input  logic            RegWriteIn,
   input  logic            Flush,
   input  logic            ExMemRegWrite,
   input  logic            MemWbRegWrite,
   input  logic [RAW-1:0]  ExMemRd,
   input  logic [RAW-1:0]  MemWbRd,
   input  logic [XLEN-1:0] ExMemResult,
   input  logic [XLEN-1:0] MemWbResult,
   output logic            OutValid,
   input  logic            OutReady,
   output logic [XLEN-1:0] SrcA,
   output logic [XLEN-1:0] SrcB,
   output logic [4:0]      ALUControl,
   output logic [RAW-1:0]  RdE,
   output logic            RegWriteE
);

`ifdef EX_OPERAND_FWD_EN
   localparam logic c_FWD_EN = 1'b1;
`else
   localparam logic c_FWD_EN = 1'b0;
`endif

   // Source indices and operand kinds of the held instruction, kept so a
   // stalled entry can pick up results that retire while it waits.
   logic [RAW-1:0]  r_rs1e;
   logic [RAW-1:0]  r_rs2e;
   logic            r_a_is_reg;
   logic            r_b_is_reg;

   logic            w_fire_in;
   logic            w_fire_out;
   logic            w_hold;
   logic            w_refresh;
   logic            w_hazard;
   logic            w_a_is_reg;
   logic            w_b_is_reg;
   logic [RAW-1:0]  w_rs1_sel;
   logic [RAW-1:0]  w_rs2_sel;
   logic [XLEN-1:0] w_base_a;
   logic [XLEN-1:0] w_base_b;
   logic [XLEN-1:0] w_fwd_a;
   logic [XLEN-1:0] w_fwd_b;
   logic [XLEN-1:0] w_cap_a;
   logic [XLEN-1:0] w_cap_b;

   assign w_a_is_reg = srca_is_reg(ALUSrcA);
   assign w_b_is_reg = ~ALUSrcB;

   assign w_fire_in  = InValid & InReady;
   assign w_fire_out = OutValid & OutReady;
   assign w_hold     = OutValid & ~OutReady;
   assign w_refresh  = w_hold & c_FWD_EN;

`ifdef EX_OPERAND_FWD_EN
   assign w_hazard = 1'b0;
`else
   logic w_rs1_dep;
   logic w_rs2_dep;

   assign w_rs1_dep = (Rs1 != '0) &
                      ((ExMemRegWrite & (ExMemRd == Rs1)) |
                       (MemWbRegWrite & (MemWbRd == Rs1)) |
                       (RegWriteE & OutValid & (RdE == Rs1)));
   assign w_rs2_dep = (Rs2 != '0) &
                      ((ExMemRegWrite & (ExMemRd == Rs2)) |
                       (MemWbRegWrite & (MemWbRd == Rs2)) |
                       (RegWriteE & OutValid & (RdE == Rs2)));
   assign w_hazard  = InValid & ((w_a_is_reg & w_rs1_dep) | (w_b_is_reg & w_rs2_dep));
`endif

   assign InReady = (~OutValid | OutReady) & ~w_hazard;

   // Capture and hold never coincide (InReady is low while held), so one
   // bypass mux per operand serves both: it looks at the incoming source
   // while idle and at the stored source while held.
   assign w_rs1_sel = w_refresh ? r_rs1e : Rs1;
   assign w_rs2_sel = w_refresh ? r_rs2e : Rs2;
   assign w_base_a  = w_refresh ? SrcA   : RD1;
   assign w_base_b  = w_refresh ? SrcB   : RD2;

   fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_a (
      .i_rs           (w_rs1_sel),
      .i_base         (w_base_a),
      .i_exmem_we     (ExMemRegWrite & c_FWD_EN),
      .i_exmem_rd     (ExMemRd),
      .i_exmem_result (ExMemResult),
      .i_memwb_we     (MemWbRegWrite & c_FWD_EN),
      .i_memwb_rd     (MemWbRd),
      .i_memwb_result (MemWbResult),
      .o_value        (w_fwd_a)
   );

   fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_b (
      .i_rs           (w_rs2_sel),
      .i_base         (w_base_b),
      .i_exmem_we     (ExMemRegWrite & c_FWD_EN),
      .i_exmem_rd     (ExMemRd),
      .i_exmem_result (ExMemResult),
      .i_memwb_we     (MemWbRegWrite & c_FWD_EN),
      .i_memwb_rd     (MemWbRd),
      .i_memwb_result (MemWbResult),
      .o_value        (w_fwd_b)
   );

   // Operand source selection for a newly captured instruction.
   always_comb begin
      w_cap_a = '0;
      case (ALUSrcA)
         SRCA_REG: w_cap_a = w_fwd_a;
         SRCA_PC:  w_cap_a = PC;
         default:  w_cap_a = '0;
      endcase
      w_cap_b = ALUSrcB ? ImmExt : w_fwd_b;
   end

   // Stage register: flush beats capture, capture beats drain and refresh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         OutValid   <= 1'b0;
         SrcA       <= '0;
         SrcB       <= '0;
         ALUControl <= 5'b00000;
         RdE        <= '0;
         RegWriteE  <= 1'b0;
         r_rs1e     <= '0;
         r_rs2e     <= '0;
         r_a_is_reg <= 1'b0;
         r_b_is_reg <= 1'b0;
      end else if (Flush) begin
         OutValid  <= 1'b0;
         RegWriteE <= 1'b0;
      end else if (w_fire_in) begin
         OutValid   <= 1'b1;
         SrcA       <= w_cap_a;
         SrcB       <= w_cap_b;
         ALUControl <= ALUControlIn;
         RdE        <= Rd;
         RegWriteE  <= RegWriteIn;
         r_rs1e     <= Rs1;
         r_rs2e     <= Rs2;
         r_a_is_reg <= w_a_is_reg;
         r_b_is_reg <= w_b_is_reg;
      end else begin
         if (w_fire_out) begin
            OutValid <= 1'b0;
         end
         if (w_refresh) begin
            if (r_a_is_reg) begin
               SrcA <= w_fwd_a;
            end
            if (r_b_is_reg) begin
               SrcB <= w_fwd_b;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_operand_stage
//  Purpose  : Directed scenarios plus randomized traffic for ex_operand_stage,
//             compared cycle by cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_operand_stage;
   import riscv_pkg::*;

`ifdef EX_OPERAND_FWD_EN
   localparam bit c_FWD = 1'b1;
`else
   localparam bit c_FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        InValid, InReady;
   logic [31:0] RD1, RD2, ImmExt, PC;
   logic [4:0]  Rs1, Rs2, Rd;
   logic [1:0]  ALUSrcA;
   logic        ALUSrcB;
   logic [4:0]  ALUControlIn;
   logic        RegWriteIn, Flush;
   logic        ExMemRegWrite, MemWbRegWrite;
   logic [4:0]  ExMemRd, MemWbRd;
   logic [31:0] ExMemResult, MemWbResult;
   logic        OutValid, OutReady;
   logic [31:0] SrcA, SrcB;
   logic [4:0]  ALUControl;
   logic [4:0]  RdE;
   logic        RegWriteE;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the stage contents.
   bit          m_valid;
   logic [31:0] m_a, m_b;
   logic [4:0]  m_ctrl, m_rd, m_rs1, m_rs2;
   bit          m_we, m_areg, m_breg;

   logic [4:0] codes [7];

   ex_operand_stage dut (
      .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
      .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .PC(PC),
      .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControlIn(ALUControlIn), .RegWriteIn(RegWriteIn), .Flush(Flush),
      .ExMemRegWrite(ExMemRegWrite), .MemWbRegWrite(MemWbRegWrite),
      .ExMemRd(ExMemRd), .MemWbRd(MemWbRd),
      .ExMemResult(ExMemResult), .MemWbResult(MemWbResult),
      .OutValid(OutValid), .OutReady(OutReady),
      .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
      .RdE(RdE), .RegWriteE(RegWriteE)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Value a register-sourced operand reads given the current bypass buses.
   function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] base);
      if (!c_FWD || rs == 5'd0) return base;
      if (ExMemRegWrite && ExMemRd == rs) return ExMemResult;
      if (MemWbRegWrite && MemWbRd == rs) return MemWbResult;
      return base;
   endfunction

   // Would register rs depend on a writer still in flight?
   function automatic bit in_flight(input logic [4:0] rs);
      if (rs == 5'd0) return 1'b0;
      return (ExMemRegWrite && ExMemRd == rs) || (MemWbRegWrite && MemWbRd == rs) ||
             (m_valid && m_we && m_rd == rs);
   endfunction

   function automatic bit model_ready();
      bit stall;
      stall = !c_FWD && InValid &&
              ((ALUSrcA == 2'b00 && in_flight(Rs1)) || (ALUSrcB == 1'b0 && in_flight(Rs2)));
      return (!m_valid || OutReady) && !stall;
   endfunction

   task automatic model_edge(input bit rdy);
      bit take, drain;
      take  = InValid && rdy;
      drain = m_valid && OutReady;
      if (Flush) begin
         m_valid = 1'b0;
         m_we    = 1'b0;
      end else if (take) begin
         m_valid = 1'b1;
         m_a     = (ALUSrcA == 2'b00) ? resolve(Rs1, RD1) : (ALUSrcA == 2'b01) ? PC : 32'd0;
         m_b     = ALUSrcB ? ImmExt : resolve(Rs2, RD2);
         m_ctrl  = ALUControlIn;
         m_rd    = Rd;
         m_we    = RegWriteIn;
         m_rs1   = Rs1;
         m_rs2   = Rs2;
         m_areg  = (ALUSrcA == 2'b00);
         m_breg  = !ALUSrcB;
      end else if (drain) begin
         m_valid = 1'b0;
      end else if (m_valid) begin
         if (m_areg) m_a = resolve(m_rs1, m_a);
         if (m_breg) m_b = resolve(m_rs2, m_b);
      end
   endtask

   // Called with inputs settled before an edge; returns 1 ns after the edge.
   task automatic cycle();
      bit rdy;
      rdy = model_ready();
      check("InReady", 32'(InReady), 32'(rdy));
      @(posedge clk);
      model_edge(rdy);
      #1;
      check("OutValid", 32'(OutValid), 32'(m_valid));
      check("RegWriteE", 32'(RegWriteE), 32'(m_we));
      if (m_valid) begin
         check("SrcA", SrcA, m_a);
         check("SrcB", SrcB, m_b);
         check("ALUControl", 32'(ALUControl), 32'(m_ctrl));
         check("RdE", 32'(RdE), 32'(m_rd));
      end
   endtask

   task automatic idle_inputs();
      InValid = 0; OutReady = 1; Flush = 0;
      RD1 = 0; RD2 = 0; ImmExt = 0; PC = 0; Rs1 = 0; Rs2 = 0; Rd = 0;
      ALUSrcA = 2'b10; ALUSrcB = 1'b1; ALUControlIn = ALU_ADD; RegWriteIn = 0;
      ExMemRegWrite = 0; MemWbRegWrite = 0; ExMemRd = 0; MemWbRd = 0;
      ExMemResult = 0; MemWbResult = 0;
   endtask

   task automatic model_reset();
      m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_we = 0;
      m_rs1 = 0; m_rs2 = 0; m_areg = 0; m_breg = 0;
   endtask

   initial begin
      codes = '{ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SLT};
      idle_inputs();
      model_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_OutValid", 32'(OutValid), 32'd0);
      check("rst_SrcA", SrcA, 32'd0);
      check("rst_ALUControl", 32'(ALUControl), 32'd0);

      // PC + immediate capture, one cycle latency.
      InValid = 1; ALUSrcA = 2'b01; PC = 32'h100; ALUSrcB = 1; ImmExt = 32'hFFFF_FFFC;
      ALUControlIn = ALU_ADD; Rd = 5'd9; RegWriteIn = 1;
      #1 cycle();
      check("pcimm_SrcA", SrcA, 32'h100);
      check("pcimm_SrcB", SrcB, 32'hFFFF_FFFC);
      check("pcimm_OutValid", 32'(OutValid), 32'd1);

      // Back-pressure for three cycles, then back-to-back replacement.
      OutReady = 0; PC = 32'h200; ALUControlIn = ALU_SUB;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_InReady", 32'(InReady), 32'd0);
         cycle();
         check("stall_SrcA", SrcA, 32'h100);
      end
      OutReady = 1;
      #1 cycle();
      check("b2b_OutValid", 32'(OutValid), 32'd1);
      check("b2b_SrcA", SrcA, 32'h200);
      check("b2b_ALUControl", 32'(ALUControl), 32'(ALU_SUB));

      // Asynchronous reset while an entry is held.
      InValid = 0; OutReady = 0;
      #1 cycle();
      reset = 1'b1;
      #1;
      check("midrst_OutValid", 32'(OutValid), 32'd0);
      check("midrst_SrcA", SrcA, 32'd0);
      check("midrst_SrcB", SrcB, 32'd0);
      check("midrst_ALUControl", 32'(ALUControl), 32'd0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      idle_inputs();

`ifdef EX_OPERAND_FWD_EN
      // Bypass priority at capture, and x0 never bypassed.
      InValid = 1; ALUSrcA = 2'b00; Rs1 = 5'd5; RD1 = 32'h11;
      ExMemRegWrite = 1; ExMemRd = 5'd5; ExMemResult = 32'h22;
      MemWbRegWrite = 1; MemWbRd = 5'd5; MemWbResult = 32'h33;
      #1 cycle();
      check("fwd_exmem_SrcA", SrcA, 32'h22);
      Rs1 = 5'd0; ExMemRd = 5'd0; RD1 = 32'h44;
      #1 cycle();
      check("fwd_x0_SrcA", SrcA, 32'h44);

      // Refresh of a held register operand from MEM/WB.
      idle_inputs();
      InValid = 1; ALUSrcB = 0; Rs2 = 5'd7; RD2 = 32'h1;
      #1 cycle();
      check("fwd_cap_SrcB", SrcB, 32'h1);
      InValid = 0; OutReady = 0; MemWbRegWrite = 1; MemWbRd = 5'd7; MemWbResult = 32'hAB;
      #1 cycle();
      check("fwd_refresh_SrcB", SrcB, 32'hAB);
`else
      // RAW dependency on the held writer stalls; flush clears it.
      InValid = 1; ALUSrcA = 2'b01; Rd = 5'd3; RegWriteIn = 1;
      #1 cycle();
      ALUSrcA = 2'b00; Rs1 = 5'd3;
      #1 check("haz_InReady", 32'(InReady), 32'd0);
      cycle();
      #1 check("haz_clear_InReady", 32'(InReady), 32'd1);
      cycle();
      OutReady = 0; Flush = 1;
      #1 check("haz_hold_InReady", 32'(InReady), 32'd0);
      cycle();
      check("flush_OutValid", 32'(OutValid), 32'd0);
      check("flush_RegWriteE", 32'(RegWriteE), 32'd0);
      Flush = 0;
      #1 check("flush_InReady", 32'(InReady), 32'd1);
      cycle();
`endif

      // Randomized traffic with a small register pool to provoke matches.
      for (int i = 0; i < 600; i++) begin
         InValid       = ($urandom_range(0, 9) < 7);
         OutReady      = ($urandom_range(0, 9) < 6);
         Flush         = ($urandom_range(0, 15) == 0);
         RD1           = $urandom;
         RD2           = $urandom;
         ImmExt        = $urandom;
         PC            = $urandom;
         Rs1           = 5'($urandom_range(0, 7));
         Rs2           = 5'($urandom_range(0, 7));
         Rd            = 5'($urandom_range(0, 7));
         ALUSrcA       = 2'($urandom_range(0, 3));
         ALUSrcB       = 1'($urandom_range(0, 1));
         ALUControlIn  = codes[$urandom_range(0, 6)];
         RegWriteIn    = 1'($urandom_range(0, 1));
         ExMemRegWrite = 1'($urandom_range(0, 1));
         MemWbRegWrite = 1'($urandom_range(0, 1));
         ExMemRd       = 5'($urandom_range(0, 7));
         MemWbRd       = 5'($urandom_range(0, 7));
         ExMemResult   = $urandom;
         MemWbResult   = $urandom;
         #1 cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
